// File: rtl/mac_operand_sequencer.sv
// Operand-issuing front end for the ALU/MAC: walks weight/activation/bias memories
// for OUT outputs of TAP taps, streams one operand pair per cycle, counts returned results.
module mac_operand_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [CNT_WIDTH-1:0]  tap_count_in,
  input  logic [CNT_WIDTH-1:0]  out_count_in,
  input  logic [ADDR_WIDTH-1:0] act_base_in,
  input  logic [ADDR_WIDTH-1:0] act_stride_in,
  input  logic [ADDR_WIDTH-1:0] w_base_in,
  input  logic [ADDR_WIDTH-1:0] b_base_in,
  input  logic                  relu_en_in,
  input  logic                  gap_en_in,
  input  logic                  pause_in,
  output logic                  w_rd_en_out,
  output logic [ADDR_WIDTH-1:0] w_addr_out,
  input  logic [DATA_WIDTH-1:0] w_rdata_in,
  output logic                  act_rd_en_out,
  output logic [ADDR_WIDTH-1:0] act_addr_out,
  input  logic [DATA_WIDTH-1:0] act_rdata_in,
  output logic                  b_rd_en_out,
  output logic [ADDR_WIDTH-1:0] b_addr_out,
  input  logic [DATA_WIDTH-1:0] b_rdata_in,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic [DATA_WIDTH-1:0] activation_out,
  output logic [DATA_WIDTH-1:0] bias_out,
  output logic                  bias_valid_out,
  output logic                  relu_en_out,
  output logic                  send_enable_out,
  output logic                  gap_enable_out,
  input  logic                  alu_valid_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  tap_q, tap_d, out_q, out_d;
  logic [CNT_WIDTH-1:0]  k_q, k_d, o_q, o_d, res_cnt_q, res_cnt_d;
  logic [ADDR_WIDTH-1:0] act_row_q, act_row_d, act_stride_q, act_stride_d;
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, b_ptr_q, b_ptr_d;
  logic                  relu_cfg_q, relu_cfg_d, gap_cfg_q, gap_cfg_d;
  logic                  w_rd_en_q, w_rd_en_d, act_rd_en_q, act_rd_en_d, b_rd_en_q, b_rd_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, act_addr_q, act_addr_d, b_addr_q, b_addr_d;
  logic                  w_v1_q, w_v1_d, act_v1_q, act_v1_d, last_v1_q, last_v1_d;
  logic [DATA_WIDTH-1:0] weight_q, weight_d, act_q, act_d, bias_q, bias_d;
  logic                  bias_valid_q, bias_valid_d;
  logic                  relu_en_q, relu_en_d, send_en_q, send_en_d, gap_en_q, gap_en_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    out_d        = out_q;
    k_d          = k_q;
    o_d          = o_q;
    act_row_d    = act_row_q;
    act_stride_d = act_stride_q;
    w_ptr_d      = w_ptr_q;
    b_ptr_d      = b_ptr_q;
    relu_cfg_d   = relu_cfg_q;
    gap_cfg_d    = gap_cfg_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    w_rd_en_d    = 1'b0;
    act_rd_en_d  = 1'b0;
    b_rd_en_d    = 1'b0;
    w_addr_d     = '0;
    act_addr_d   = '0;
    b_addr_d     = '0;
    res_cnt_d    = res_cnt_q + CNT_WIDTH'(busy_q & alu_valid_in);

    // Two-stage return path: strobe cycle -> RAM data cycle -> output register.
    w_v1_d       = w_rd_en_q;
    act_v1_d     = act_rd_en_q;
    last_v1_d    = b_rd_en_q;
    weight_d     = w_v1_q    ? w_rdata_in   : '0;
    act_d        = act_v1_q  ? act_rdata_in : '0;
    bias_d       = last_v1_q ? b_rdata_in   : '0;
    bias_valid_d = last_v1_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (tap_count_in == '0 || out_count_in == '0) begin
            err_d = 1'b1;
          end else begin
            tap_d        = tap_count_in;
            out_d        = out_count_in;
            act_row_d    = act_base_in;
            act_stride_d = act_stride_in;
            w_ptr_d      = w_base_in;
            b_ptr_d      = b_base_in;
            relu_cfg_d   = relu_en_in;
            gap_cfg_d    = gap_en_in;
            k_d          = '0;
            o_d          = '0;
            res_cnt_d    = '0;
            busy_d       = 1'b1;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!pause_in) begin
          act_rd_en_d = 1'b1;
          act_addr_d  = act_row_q + ADDR_WIDTH'(k_q);
          w_rd_en_d   = !gap_cfg_q;
          w_addr_d    = gap_cfg_q ? '0 : w_ptr_q;
          w_ptr_d     = w_ptr_q + ADDR_WIDTH'(1);
          if (k_q == tap_q - CNT_WIDTH'(1)) begin
            // Last tap of this output: fetch its bias, step to the next activation row.
            b_rd_en_d = 1'b1;
            b_addr_d  = b_ptr_q;
            b_ptr_d   = b_ptr_q + ADDR_WIDTH'(1);
            act_row_d = act_row_q + act_stride_q;
            k_d       = '0;
            o_d       = o_q + CNT_WIDTH'(1);
            if (o_q == out_q - CNT_WIDTH'(1)) begin
              state_d = S_DRAIN;
            end
          end else begin
            k_d = k_q + CNT_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (res_cnt_d == out_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    send_en_d = busy_d;
    relu_en_d = busy_d & relu_cfg_d;
    gap_en_d  = busy_d & gap_cfg_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      out_q        <= '0;
      k_q          <= '0;
      o_q          <= '0;
      res_cnt_q    <= '0;
      act_row_q    <= '0;
      act_stride_q <= '0;
      w_ptr_q      <= '0;
      b_ptr_q      <= '0;
      relu_cfg_q   <= 1'b0;
      gap_cfg_q    <= 1'b0;
      w_rd_en_q    <= 1'b0;
      act_rd_en_q  <= 1'b0;
      b_rd_en_q    <= 1'b0;
      w_addr_q     <= '0;
      act_addr_q   <= '0;
      b_addr_q     <= '0;
      w_v1_q       <= 1'b0;
      act_v1_q     <= 1'b0;
      last_v1_q    <= 1'b0;
      weight_q     <= '0;
      act_q        <= '0;
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      relu_en_q    <= 1'b0;
      send_en_q    <= 1'b0;
      gap_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      out_q        <= out_d;
      k_q          <= k_d;
      o_q          <= o_d;
      res_cnt_q    <= res_cnt_d;
      act_row_q    <= act_row_d;
      act_stride_q <= act_stride_d;
      w_ptr_q      <= w_ptr_d;
      b_ptr_q      <= b_ptr_d;
      relu_cfg_q   <= relu_cfg_d;
      gap_cfg_q    <= gap_cfg_d;
      w_rd_en_q    <= w_rd_en_d;
      act_rd_en_q  <= act_rd_en_d;
      b_rd_en_q    <= b_rd_en_d;
      w_addr_q     <= w_addr_d;
      act_addr_q   <= act_addr_d;
      b_addr_q     <= b_addr_d;
      w_v1_q       <= w_v1_d;
      act_v1_q     <= act_v1_d;
      last_v1_q    <= last_v1_d;
      weight_q     <= weight_d;
      act_q        <= act_d;
      bias_q       <= bias_d;
      bias_valid_q <= bias_valid_d;
      relu_en_q    <= relu_en_d;
      send_en_q    <= send_en_d;
      gap_en_q     <= gap_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign w_rd_en_out     = w_rd_en_q;
  assign w_addr_out      = w_addr_q;
  assign act_rd_en_out   = act_rd_en_q;
  assign act_addr_out    = act_addr_q;
  assign b_rd_en_out     = b_rd_en_q;
  assign b_addr_out      = b_addr_q;
  assign weight_out      = weight_q;
  assign activation_out  = act_q;
  assign bias_out        = bias_q;
  assign bias_valid_out  = bias_valid_q;
  assign relu_en_out     = relu_en_q;
  assign send_enable_out = send_en_q;
  assign gap_enable_out  = gap_en_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer: memory and ALU stubs plus a
// tap-list reference model built from the address/latency rules.
module tb_mac_operand_sequencer;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk, rst, start_in, relu_en_in, gap_en_in, pause_in, alu_valid_in;
  logic [CW-1:0] tap_count_in, out_count_in;
  logic [AW-1:0] act_base_in, act_stride_in, w_base_in, b_base_in;
  logic          w_rd_en_out, act_rd_en_out, b_rd_en_out;
  logic [AW-1:0] w_addr_out, act_addr_out, b_addr_out;
  logic [DW-1:0] w_rdata_in, act_rdata_in, b_rdata_in;
  logic [DW-1:0] weight_out, activation_out, bias_out;
  logic          bias_valid_out, relu_en_out, send_enable_out, gap_enable_out;
  logic          busy_out, done_out, err_out;

  logic [DW-1:0] w_mem [256];
  logic [DW-1:0] act_mem [256];
  logic [DW-1:0] b_mem [256];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int            due;
    logic [AW-1:0] act_addr, w_addr, b_addr;
    bit            last;
    logic [DW-1:0] weight, act, bias;
  } tap_t;

  mac_operand_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .tap_count_in(tap_count_in), .out_count_in(out_count_in),
    .act_base_in(act_base_in), .act_stride_in(act_stride_in),
    .w_base_in(w_base_in), .b_base_in(b_base_in),
    .relu_en_in(relu_en_in), .gap_en_in(gap_en_in), .pause_in(pause_in),
    .w_rd_en_out(w_rd_en_out), .w_addr_out(w_addr_out), .w_rdata_in(w_rdata_in),
    .act_rd_en_out(act_rd_en_out), .act_addr_out(act_addr_out), .act_rdata_in(act_rdata_in),
    .b_rd_en_out(b_rd_en_out), .b_addr_out(b_addr_out), .b_rdata_in(b_rdata_in),
    .weight_out(weight_out), .activation_out(activation_out), .bias_out(bias_out),
    .bias_valid_out(bias_valid_out), .relu_en_out(relu_en_out),
    .send_enable_out(send_enable_out), .gap_enable_out(gap_enable_out),
    .alu_valid_in(alu_valid_in), .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAMs; unstrobed cycles return junk so bubbles must be masked.
  always @(posedge clk) begin
    w_rdata_in   <= w_rd_en_out   ? w_mem[w_addr_out]     : DW'($urandom);
    act_rdata_in <= act_rd_en_out ? act_mem[act_addr_out] : DW'($urandom);
    b_rdata_in   <= b_rd_en_out   ? b_mem[b_addr_out]     : DW'($urandom);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_w_rd_en"}, w_rd_en_out, 0);
    check_eq({tag, "_w_addr"}, w_addr_out, 0);
    check_eq({tag, "_act_rd_en"}, act_rd_en_out, 0);
    check_eq({tag, "_act_addr"}, act_addr_out, 0);
    check_eq({tag, "_b_rd_en"}, b_rd_en_out, 0);
    check_eq({tag, "_b_addr"}, b_addr_out, 0);
    check_eq({tag, "_weight"}, weight_out, 0);
    check_eq({tag, "_act"}, activation_out, 0);
    check_eq({tag, "_bias"}, bias_out, 0);
    check_eq({tag, "_bias_valid"}, bias_valid_out, 0);
    check_eq({tag, "_relu"}, relu_en_out, 0);
    check_eq({tag, "_send"}, send_enable_out, 0);
    check_eq({tag, "_gap"}, gap_enable_out, 0);
    check_eq({tag, "_busy"}, busy_out, 0);
    check_eq({tag, "_done"}, done_out, 0);
    check_eq({tag, "_err"}, err_out, 0);
  endtask

  task automatic zero_start(input int tap, input int outn);
    @(posedge clk); #1;
    tap_count_in = CW'(tap);
    out_count_in = CW'(outn);
    start_in     = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(negedge clk);
    check_eq("zero_err_pulse", err_out, 1);
    check_eq("zero_busy", busy_out, 0);
    check_eq("zero_strobe", act_rd_en_out, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("zero_err_clear", err_out, 0);
    check_eq("zero_busy2", busy_out, 0);
  endtask

  task automatic run_job(input int tap, input int outn, input int abase, input int astride,
                         input int wbase, input int bbase, input bit relu, input bit gap,
                         input int pause_pct, input int pause_cyc, input int restart_cyc,
                         input int abort_cyc);
    tap_t   exp_q[$];
    tap_t   op_q[$];
    int     alu_due[$];
    longint res_q[$];
    tap_t   t;
    longint sum, acc, got;
    int     total, nstrobe, sched, nalu, done_cyc, cyc;
    bit     strobe_now, strobe_next, exp_busy;

    total = tap * outn;
    for (int o = 0; o < outn; o++) begin
      sum = 0;
      for (int k = 0; k < tap; k++) begin
        t.due      = 0;
        t.act_addr = AW'(abase + o * astride + k);
        t.w_addr   = AW'(wbase + o * tap + k);
        t.b_addr   = AW'(bbase + o);
        t.last     = (k == tap - 1);
        t.weight   = gap ? '0 : w_mem[t.w_addr];
        t.act      = act_mem[t.act_addr];
        t.bias     = t.last ? b_mem[t.b_addr] : '0;
        sum += longint'($signed(t.weight)) * longint'($signed(t.act));
        if (t.last) res_q.push_back(sum + longint'($signed(t.bias)));
        exp_q.push_back(t);
      end
    end

    @(posedge clk); #1;
    tap_count_in  = CW'(tap);
    out_count_in  = CW'(outn);
    act_base_in   = AW'(abase);
    act_stride_in = AW'(astride);
    w_base_in     = AW'(wbase);
    b_base_in     = AW'(bbase);
    relu_en_in    = relu;
    gap_en_in     = gap;
    pause_in      = 1'b0;
    alu_valid_in  = 1'b0;
    start_in      = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;

    nstrobe = 0; sched = 0; nalu = 0; done_cyc = -1; strobe_now = 0; acc = 0;
    cyc = 1;
    forever begin
      pause_in     = (cyc == pause_cyc) || ($urandom_range(99) < pause_pct);
      alu_valid_in = 1'b0;
      if (alu_due.size() != 0 && alu_due[0] == cyc) begin
        void'(alu_due.pop_front());
        alu_valid_in = 1'b1;
        nalu++;
        if (nalu == outn) done_cyc = cyc + 1;
      end
      start_in = (cyc == restart_cyc);
      if (start_in) begin
        tap_count_in = CW'($urandom_range(1, 255));
        out_count_in = CW'($urandom_range(1, 255));
        act_base_in  = AW'($urandom);
      end
      rst = (cyc == abort_cyc);
      strobe_next = (sched < total) && !pause_in;
      if (strobe_next) sched++;

      @(negedge clk);
      exp_busy = (done_cyc < 0) || (cyc < done_cyc);
      check_eq("busy", busy_out, exp_busy);
      check_eq("done", done_out, cyc == done_cyc);
      check_eq("err_while_busy", err_out, 0);
      check_eq("send_enable", send_enable_out, exp_busy);
      check_eq("relu_en", relu_en_out, exp_busy & relu);
      check_eq("gap_enable", gap_enable_out, exp_busy & gap);

      if (strobe_now) begin
        t = exp_q[nstrobe];
        check_eq("act_rd_en", act_rd_en_out, 1);
        check_eq("act_addr", act_addr_out, t.act_addr);
        check_eq("w_rd_en", w_rd_en_out, !gap);
        if (!gap) check_eq("w_addr", w_addr_out, t.w_addr);
        check_eq("b_rd_en", b_rd_en_out, t.last);
        if (t.last) check_eq("b_addr", b_addr_out, t.b_addr);
        t.due = cyc + 2;
        op_q.push_back(t);
        nstrobe++;
      end else begin
        check_eq("act_rd_en_idle", act_rd_en_out, 0);
        check_eq("w_rd_en_idle", w_rd_en_out, 0);
        check_eq("b_rd_en_idle", b_rd_en_out, 0);
      end

      if (op_q.size() != 0 && op_q[0].due == cyc) begin
        t = op_q.pop_front();
        check_eq("weight", weight_out, t.weight);
        check_eq("activation", activation_out, t.act);
        check_eq("bias_valid", bias_valid_out, t.last);
        if (t.last) begin
          check_eq("bias", bias_out, t.bias);
          alu_due.push_back(cyc + 2);
        end
      end else begin
        check_eq("bubble_weight", weight_out, 0);
        check_eq("bubble_act", activation_out, 0);
        check_eq("bubble_bias_valid", bias_valid_out, 0);
      end

      acc += longint'($signed(weight_out)) * longint'($signed(activation_out));
      if (bias_valid_out) begin
        got = acc + longint'($signed(bias_out));
        if (res_q.size() != 0) check_eq("mac_result", got, res_q.pop_front());
        else check_eq("extra_bias_valid", 1, 0);
        acc = 0;
      end

      if (cyc == abort_cyc) begin
        @(posedge clk); #1;
        rst = 1'b0; start_in = 1'b0; pause_in = 1'b0; alu_valid_in = 1'b0;
        @(negedge clk);
        check_idle("abort");
        return;
      end
      if (cyc == done_cyc) break;
      if (cyc >= 3000) begin
        check_eq("timeout", 1, 0);
        break;
      end
      strobe_now = strobe_next;
      cyc++;
      @(posedge clk); #1;
    end
    start_in = 1'b0; pause_in = 1'b0; alu_valid_in = 1'b0;
    check_eq("taps_issued", nstrobe, total);
    check_eq("results_left", res_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; relu_en_in = 1'b0; gap_en_in = 1'b0;
    pause_in = 1'b0; alu_valid_in = 1'b0;
    tap_count_in = '0; out_count_in = '0;
    act_base_in = '0; act_stride_in = '0; w_base_in = '0; b_base_in = '0;
    for (int i = 0; i < 256; i++) begin
      w_mem[i]   = DW'($urandom);
      act_mem[i] = DW'($urandom);
      b_mem[i]   = DW'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_job(2, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    run_job(4, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    run_job(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_job(4, 2, 10, 5, 20, 30, 1, 1, 0, 0, 0, 0);
    zero_start(0, 5);
    zero_start(3, 0);
    run_job(3, 2, 7, 3, 9, 4, 1, 0, 0, 0, 3, 0);
    run_job(8, 2, 0, 8, 0, 0, 0, 0, 0, 0, 0, 5);
    run_job(8, 2, 0, 8, 0, 0, 1, 0, 0, 0, 0, 0);
    run_job(40, 8, 250, 37, 200, 252, 0, 0, 20, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run_job($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              1'($urandom_range(0, 1)), (i % 3) == 0, 30, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
